slink_gpio_deserializer: RTL and testbench

- Receive-side counterpart of slink_gpio_serializer. It samples an IO_DATA_WIDTH-bit serial lane on serial_clk and aligns to a sync word. It then reassembles PAR_DATA_WIDTH-bit parallel words and presents them with a one-cycle valid strobe.
- It sits between the GPIO pad interface and the S-Link PHY-side parallel receive path.

---
 rtl/slink_gpio_pkg.sv | 27 ++
 rtl/slink_gpio_deser_shift.sv | 59 +++++
 rtl/slink_gpio_deserializer.sv | 167 ++++++++++++++++
 tb/tb_slink_gpio_deserializer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slink_gpio_pkg.sv
// Shared definitions for the S-Link GPIO serializer/deserializer pair.
package slink_gpio_pkg;

    // Receive-side alignment state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_DATA  = 2'd2
    } slink_state_e;

    // Default alignment pattern, shared with the serializer so both ends agree
    localparam logic [7:0] SLINK_SYNC_WORD = 8'hBC;

    // Gap counter width; covers the full GAP_TIMEOUT range 1..255
    localparam int unsigned SLINK_GAP_W = 8;

    // Number of serial beats needed to assemble one parallel word
    function automatic int unsigned slink_beats(input int unsigned par_w, input int unsigned io_w);
        return par_w / io_w;
    endfunction

    // Beat counter width, never narrower than one bit
    function automatic int unsigned slink_cnt_width(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/slink_gpio_deser_shift.sv
// LSB-first shift register and beat counter for the GPIO deserializer.
module slink_gpio_deser_shift
    import slink_gpio_pkg::*;
#(
    parameter int unsigned PAR_DATA_WIDTH = 8,
    parameter int unsigned IO_DATA_WIDTH  = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clr_all,
    input  logic                      i_clr_cnt,
    input  logic                      i_shift,
    input  logic                      i_count,
    input  logic [IO_DATA_WIDTH-1:0]  i_data,
    output logic [PAR_DATA_WIDTH-1:0] o_sr_next,
    output logic                      o_last
);

    localparam int unsigned BEATS    = slink_beats(PAR_DATA_WIDTH, IO_DATA_WIDTH);
    localparam int unsigned CNT_W    = slink_cnt_width(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    logic [PAR_DATA_WIDTH-1:0] r_sr;
    logic [CNT_W-1:0]          r_cnt;
    logic [PAR_DATA_WIDTH-1:0] w_sr_next;

    // Next shift value: new beat enters at the top, older beats move toward bit 0
    generate
        if (BEATS > 1) begin : g_multi_beat
            assign w_sr_next = {i_data, r_sr[PAR_DATA_WIDTH-1:IO_DATA_WIDTH]};
        end else begin : g_single_beat
            assign w_sr_next = i_data;
        end
    endgenerate

    // Shift register and wrapping beat counter with clear controls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_clr_all) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_shift) begin
                r_sr <= w_sr_next;
            end
            if (i_clr_cnt) begin
                r_cnt <= '0;
            end else if (i_count) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_sr_next = w_sr_next;
    assign o_last    = (r_cnt == CNT_LAST);

endmodule

// File: rtl/slink_gpio_deserializer.sv
// GPIO lane deserializer: hunts for the sync word, then rebuilds parallel words.
module slink_gpio_deserializer
    import slink_gpio_pkg::*;
#(
    parameter int unsigned               PAR_DATA_WIDTH = 8,
    parameter int unsigned               IO_DATA_WIDTH  = 2,
    parameter logic [PAR_DATA_WIDTH-1:0] SYNC_WORD      = PAR_DATA_WIDTH'(SLINK_SYNC_WORD),
    parameter bit                        ALIGN_EN       = 1'b1,
    parameter int unsigned               GAP_TIMEOUT    = 16
) (
    input  logic                      serial_clk,
    input  logic                      serial_reset_n,
    input  logic                      rx_en,
    input  logic                      rx_ser_io_en,
    input  logic [IO_DATA_WIDTH-1:0]  rx_ser_data,
    output logic [PAR_DATA_WIDTH-1:0] rx_par_data,
    output logic                      rx_par_valid,
    output logic                      rx_aligned,
    output logic                      rx_align_err
);

    localparam logic [SLINK_GAP_W-1:0] GAP_LAST = SLINK_GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [SLINK_GAP_W-1:0] GAP_MAX  = SLINK_GAP_W'(GAP_TIMEOUT);

    slink_state_e              r_state;
    logic [SLINK_GAP_W-1:0]    r_gap;
    logic [PAR_DATA_WIDTH-1:0] r_par_data;
    logic                      r_par_valid;
    logic                      r_aligned;
    logic                      r_align_err;

    logic                      w_beat;
    logic                      w_sync_hit;
    logic                      w_timeout;
    logic                      w_clr_all;
    logic                      w_clr_cnt;
    logic                      w_shift;
    logic                      w_count;
    logic                      w_last;
    logic [PAR_DATA_WIDTH-1:0] w_sr_next;

    // Shift path and beat counter
    slink_gpio_deser_shift #(
        .PAR_DATA_WIDTH (PAR_DATA_WIDTH),
        .IO_DATA_WIDTH  (IO_DATA_WIDTH)
    ) u_shift (
        .i_clk     (serial_clk),
        .i_rst_n   (serial_reset_n),
        .i_clr_all (w_clr_all),
        .i_clr_cnt (w_clr_cnt),
        .i_shift   (w_shift),
        .i_count   (w_count),
        .i_data    (rx_ser_data),
        .o_sr_next (w_sr_next),
        .o_last    (w_last)
    );

    // Event decode: beat, sync match including the incoming beat, gap expiry
    always_comb begin
        w_beat     = rx_ser_io_en;
        w_sync_hit = rx_ser_io_en && (w_sr_next == SYNC_WORD);
        w_timeout  = (r_state == ST_DATA) && !rx_ser_io_en && (r_gap == GAP_LAST);
    end

    // Shift-path controls; rx_en low overrides everything
    always_comb begin
        w_clr_all = 1'b0;
        w_clr_cnt = 1'b0;
        w_shift   = 1'b0;
        w_count   = 1'b0;
        if (!rx_en) begin
            w_clr_all = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_clr_all = 1'b1;
                end
                ST_ALIGN: begin
                    w_shift   = w_beat;
                    w_clr_cnt = 1'b1;
                end
                ST_DATA: begin
                    w_shift = w_beat;
                    w_count = w_beat;
                    if (w_timeout) begin
                        w_clr_all = ALIGN_EN;
                        w_clr_cnt = !ALIGN_EN;
                    end
                end
                default: begin
                    w_clr_all = 1'b1;
                end
            endcase
        end
    end

    // Alignment FSM, gap counter and registered outputs
    always_ff @(posedge serial_clk or negedge serial_reset_n) begin
        if (!serial_reset_n) begin
            r_state     <= ST_IDLE;
            r_gap       <= '0;
            r_par_data  <= '0;
            r_par_valid <= 1'b0;
            r_aligned   <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_par_valid <= 1'b0;
            r_align_err <= 1'b0;
            if (!rx_en) begin
                r_state   <= ST_IDLE;
                r_gap     <= '0;
                r_aligned <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_gap <= '0;
                        if (ALIGN_EN) begin
                            r_state <= ST_ALIGN;
                        end else begin
                            r_state   <= ST_DATA;
                            r_aligned <= 1'b1;
                        end
                    end
                    ST_ALIGN: begin
                        if (w_sync_hit) begin
                            r_state   <= ST_DATA;
                            r_aligned <= 1'b1;
                            r_gap     <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (w_beat) begin
                            r_gap <= '0;
                            if (w_last) begin
                                r_par_data  <= w_sr_next;
                                r_par_valid <= 1'b1;
                            end
                        end else if (w_timeout) begin
                            r_align_err <= 1'b1;
                            if (ALIGN_EN) begin
                                r_state   <= ST_ALIGN;
                                r_aligned <= 1'b0;
                                r_gap     <= '0;
                            end else begin
                                // Saturate so a long idle stretch reports only once
                                r_gap <= GAP_MAX;
                            end
                        end else if (r_gap != GAP_MAX) begin
                            r_gap <= r_gap + SLINK_GAP_W'(1);
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_gap     <= '0;
                        r_aligned <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_par_data  = r_par_data;
    assign rx_par_valid = r_par_valid;
    assign rx_aligned   = r_aligned;
    assign rx_align_err = r_align_err;

endmodule

// File: tb/tb_slink_gpio_deserializer.sv
// Scoreboard bench for slink_gpio_deserializer (aligned and free-running variants).
module tb_slink_gpio_deserializer;

    localparam int PAR   = 8;
    localparam int IO    = 2;
    localparam int BEATS = PAR / IO;
    localparam int GAP   = 16;
    localparam logic [PAR-1:0] SYNC = 8'hBC;

    typedef struct {
        logic [PAR-1:0] d;
        int unsigned    c;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rx_en_a;
    logic           rx_en_b;
    logic           io_en;
    logic [IO-1:0]  ser;
    logic [PAR-1:0] par_a, par_b;
    logic           valid_a, valid_b;
    logic           aligned_a, aligned_b;
    logic           err_a, err_b;

    int unsigned cyc = 0;
    int unsigned last_beat_cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          errs_b = 0;

    exp_t        q_a[$];
    exp_t        q_b[$];
    int unsigned q_err[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    slink_gpio_deserializer #(
        .PAR_DATA_WIDTH (PAR),
        .IO_DATA_WIDTH  (IO),
        .SYNC_WORD      (SYNC),
        .ALIGN_EN       (1'b1),
        .GAP_TIMEOUT    (GAP)
    ) dut_a (
        .serial_clk     (clk),
        .serial_reset_n (rst_n),
        .rx_en          (rx_en_a),
        .rx_ser_io_en   (io_en),
        .rx_ser_data    (ser),
        .rx_par_data    (par_a),
        .rx_par_valid   (valid_a),
        .rx_aligned     (aligned_a),
        .rx_align_err   (err_a)
    );

    slink_gpio_deserializer #(
        .PAR_DATA_WIDTH (PAR),
        .IO_DATA_WIDTH  (IO),
        .SYNC_WORD      (SYNC),
        .ALIGN_EN       (1'b0),
        .GAP_TIMEOUT    (GAP)
    ) dut_b (
        .serial_clk     (clk),
        .serial_reset_n (rst_n),
        .rx_en          (rx_en_b),
        .rx_ser_io_en   (io_en),
        .rx_ser_data    (ser),
        .rx_par_data    (par_b),
        .rx_par_valid   (valid_b),
        .rx_aligned     (aligned_b),
        .rx_align_err   (err_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the aligning instance: words and alignment errors
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n) begin
            while (q_a.size() > 0 && q_a[0].c < cyc) begin
                e = q_a.pop_front();
                checks++; errors++;
                $display("FAIL missed_word_a: no strobe at cycle %0d for data 0x%0h", e.c, e.d);
            end
            if (valid_a) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word_a: data 0x%0h at cycle %0d", par_a, cyc);
                end else begin
                    e = q_a.pop_front();
                    if (par_a !== e.d || cyc != e.c) begin
                        errors++;
                        $display("FAIL word_a: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d", par_a, cyc, e.d, e.c);
                    end
                end
            end
            while (q_err.size() > 0 && q_err[0] < cyc) begin
                checks++; errors++;
                $display("FAIL missed_align_err: none at cycle %0d", q_err.pop_front());
            end
            if (err_a) begin
                checks++;
                if (q_err.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_align_err at cycle %0d", cyc);
                end else if (q_err.pop_front() != cyc) begin
                    errors++;
                    $display("FAIL align_err_timing: pulse at cycle %0d not the expected one", cyc);
                end
            end
        end
    end

    // Monitor for the free-running instance
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n) begin
            while (q_b.size() > 0 && q_b[0].c < cyc) begin
                e = q_b.pop_front();
                checks++; errors++;
                $display("FAIL missed_word_b: no strobe at cycle %0d for data 0x%0h", e.c, e.d);
            end
            if (valid_b) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word_b: data 0x%0h at cycle %0d", par_b, cyc);
                end else begin
                    e = q_b.pop_front();
                    if (par_b !== e.d || cyc != e.c) begin
                        errors++;
                        $display("FAIL word_b: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d", par_b, cyc, e.d, e.c);
                    end
                end
            end
            if (err_b) errs_b++;
        end
    end

    task automatic do_beat(input logic [IO-1:0] d);
        @(negedge clk);
        io_en = 1'b1;
        ser   = d;
        last_beat_cyc = cyc;
    endtask

    task automatic do_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            io_en = 1'b0;
            ser   = IO'($urandom);
        end
    endtask

    // Send one word LSB-first; the strobe is expected one cycle after the last beat
    task automatic send_word(input logic [PAR-1:0] w, input int stall, input bit exp_a, input bit exp_b);
        for (int k = 0; k < BEATS; k++) begin
            if (k > 0) do_idle(stall);
            do_beat(w[k*IO +: IO]);
        end
        if (exp_a) q_a.push_back('{d: w, c: cyc + 1});
        if (exp_b) q_b.push_back('{d: w, c: cyc + 1});
    endtask

    // Model of the hunt: does any window of the last BEATS beats (zero-filled) equal SYNC?
    function automatic bit prefix_hits(input logic [IO-1:0] bq[$]);
        for (int i = 0; i < bq.size(); i++) begin
            logic [PAR-1:0] w;
            w = '0;
            for (int k = 0; k < BEATS; k++) begin
                int idx;
                idx = i - (BEATS - 1) + k;
                if (idx >= 0) w = w | (PAR'(bq[idx]) << (k * IO));
            end
            if (w == SYNC) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit strays_ok(input logic [IO-1:0] strays[$]);
        logic [IO-1:0]  bq[$];
        logic [PAR-1:0] s;
        s  = SYNC;
        bq = strays;
        for (int k = 0; k < BEATS - 1; k++) bq.push_back(s[k*IO +: IO]);
        return !prefix_hits(bq);
    endfunction

    task automatic gen_strays(input int n, output logic [IO-1:0] strays[$]);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            strays.delete();
            for (int i = 0; i < n; i++) strays.push_back(IO'($urandom));
            ok = strays_ok(strays);
        end
        if (!ok) strays.delete();
    endtask

    // Stray beats, then the sync word; alignment is visible the cycle after it completes
    task automatic hunt_a(input logic [IO-1:0] strays[$]);
        foreach (strays[i]) do_beat(strays[i]);
        send_word(SYNC, 0, 1'b0, 1'b0);
        fork
            begin
                @(negedge clk);
                chk("aligned_after_sync", aligned_a, 1);
            end
        join_none
    endtask

    task automatic enable_a();
        @(negedge clk);
        rx_en_a = 1'b1;
        io_en   = 1'b0;
    endtask

    task automatic disable_a();
        @(negedge clk);
        rx_en_a = 1'b0;
        io_en   = 1'b0;
        do_idle(2);
        chk("aligned_after_disable", aligned_a, 0);
    endtask

    // Two beats, then a full idle timeout: one error pulse 17 cycles after the last beat
    task automatic gap_timeout_a(input int nbeats);
        for (int i = 0; i < nbeats; i++) do_beat(IO'($urandom));
        q_err.push_back(last_beat_cyc + GAP + 1);
        do_idle(GAP + 2);
        chk("aligned_after_timeout", aligned_a, 0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [IO-1:0]  strays[$];
        logic [IO-1:0]  none[$];
        logic [PAR-1:0] w;
        int             nw;
        int             stall;

        rst_n = 1'b0; rx_en_a = 1'b0; rx_en_b = 1'b0; io_en = 1'b0; ser = '0;
        repeat (3) @(negedge clk);
        chk("reset_par_data", par_a, 0);
        chk("reset_par_valid", valid_a, 0);
        chk("reset_aligned", aligned_a, 0);
        chk("reset_align_err", err_a, 0);
        chk("reset_aligned_b", aligned_b, 0);
        #1 rst_n = 1'b1;

        // Sync then data, back to back
        enable_a();
        do_idle(1);
        chk("aligned_during_hunt", aligned_a, 0);
        hunt_a(none);
        send_word(8'h5A, 0, 1'b1, 1'b0);
        do_idle(3);
        disable_a();

        // Misaligned hunt with a stray beat
        enable_a();
        strays.delete(); strays.push_back(2'b01);
        hunt_a(strays);
        send_word(8'hC3, 0, 1'b1, 1'b0);
        do_idle(2);

        // Stalled beats below the gap limit
        send_word(8'h5A, 3, 1'b1, 1'b0);
        do_idle(2);
        chk("par_data_hold", par_a, 8'h5A);

        // Gap timeout drops alignment, then re-hunt
        gap_timeout_a(2);
        hunt_a(none);
        send_word(8'hA5, 0, 1'b1, 1'b0);
        do_idle(2);

        // Disable coinciding with the final beat
        for (int k = 0; k < BEATS - 1; k++) do_beat(IO'($urandom));
        @(negedge clk);
        io_en = 1'b1; ser = IO'($urandom); rx_en_a = 1'b0;
        do_idle(3);
        chk("aligned_after_mid_disable", aligned_a, 0);
        chk("par_data_retained", par_a, 8'hA5);

        // Asynchronous reset mid-word
        enable_a();
        hunt_a(none);
        do_beat(2'b10);
        do_beat(2'b10);
        @(negedge clk);
        io_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_par_data", par_a, 0);
        chk("async_par_valid", valid_a, 0);
        chk("async_aligned", aligned_a, 0);
        chk("async_align_err", err_a, 0);
        rx_en_a = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Free-running variant: no sync word, timeout keeps alignment
        @(negedge clk);
        rx_en_b = 1'b1; io_en = 1'b0;
        send_word(8'h5A, 0, 1'b0, 1'b1);
        do_idle(1);
        chk("b_aligned", aligned_b, 1);
        do_beat(2'b11);
        do_beat(2'b00);
        do_idle(GAP + 2);
        chk("b_timeout_pulses", errs_b, 1);
        chk("b_aligned_after_timeout", aligned_b, 1);
        send_word(8'h3C, 1, 1'b0, 1'b1);
        do_idle(GAP + 4);
        chk("b_timeout_pulses_2", errs_b, 2);
        @(negedge clk);
        rx_en_b = 1'b0;
        do_idle(2);
        chk("b_aligned_after_disable", aligned_b, 0);

        // Randomized sessions on the aligning instance
        for (int it = 0; it < 20; it++) begin
            enable_a();
            gen_strays($urandom_range(0, 3), strays);
            hunt_a(strays);
            nw = $urandom_range(1, 5);
            for (int j = 0; j < nw; j++) begin
                w     = ($urandom_range(0, 7) == 0) ? SYNC : PAR'($urandom);
                stall = ($urandom_range(0, 9) == 0) ? GAP - 1 : $urandom_range(0, 2);
                send_word(w, stall, 1'b1, 1'b0);
                do_idle($urandom_range(0, 4));
            end
            case ($urandom_range(0, 2))
                0: disable_a();
                1: begin
                    for (int k = 0; k < $urandom_range(1, BEATS - 1); k++) do_beat(IO'($urandom));
                    disable_a();
                end
                default: begin
                    gap_timeout_a($urandom_range(0, BEATS - 1));
                    disable_a();
                end
            endcase
        end

        do_idle(5);
        chk("queue_a_drained", q_a.size(), 0);
        chk("queue_b_drained", q_b.size(), 0);
        chk("queue_err_drained", q_err.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
